// File: rtl/alu_arb_pkg.sv
// Shared encodings for the ALU arbiter: operation codes and arbiter state.
package alu_arb_pkg;

  typedef enum logic {
    OP_ADD  = 1'b0,
    OP_NAND = 1'b1
  } op_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single combinational ALU: wrapping ADD or bitwise NAND, plus operand equality.
module alu_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int p_WORD_LEN = 16
) (
  input  logic                  i_op,
  input  logic [p_WORD_LEN-1:0] i_a,
  input  logic [p_WORD_LEN-1:0] i_b,
  output logic [p_WORD_LEN-1:0] o_out,
  output logic                  o_eq
);

  // Result select; the sum is truncated to the word width so the carry is dropped.
  always_comb begin
    o_out = i_a + i_b;
    if (op_e'(i_op) == OP_NAND) begin
      o_out = ~(i_a & i_b);
    end
    o_eq = (i_a == i_b);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter with per-requester grant locking in front of one shared ALU.
// A single registered response stage; a new request is accepted whenever that
// stage is empty or being drained in the same cycle.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int p_WORD_LEN = 16,
  parameter int p_NUM_REQ  = 4,
  parameter int p_ID_W     = $clog2(p_NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [p_NUM_REQ-1:0]            i_req_valid,
  output logic [p_NUM_REQ-1:0]            o_req_ready,
  input  logic [p_NUM_REQ-1:0]            i_req_op,
  input  logic [p_NUM_REQ-1:0]            i_req_lock,
  input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_req_a,
  input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_req_b,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [p_ID_W-1:0]               o_rsp_id,
  output logic [p_WORD_LEN-1:0]           o_rsp_out,
  output logic                            o_rsp_eq
);

  // Returns {found, id}: first valid requester searching upward from ptr, wrapping.
  function automatic logic [p_ID_W:0] rr_pick(input logic [p_NUM_REQ-1:0] vld,
                                             input logic [p_ID_W-1:0]    ptr);
    logic              found;
    logic [p_ID_W-1:0] id;
    int                idx;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < p_NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % p_NUM_REQ;
      if (!found && vld[idx]) begin
        found = 1'b1;
        id    = p_ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  state_e                state_q, state_d;
  logic [p_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [p_ID_W-1:0]     lock_id_q, lock_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [p_ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [p_WORD_LEN-1:0] rsp_out_q, rsp_out_d;
  logic                  rsp_eq_q, rsp_eq_d;

  logic                  can_accept;
  logic [p_ID_W:0]       pick;
  logic                  gnt_vld;
  logic [p_ID_W-1:0]     gnt_id;
  logic                  xfer;
  logic [p_WORD_LEN-1:0] a_sel, b_sel;
  logic                  op_sel;
  logic [p_WORD_LEN-1:0] alu_out;
  logic                  alu_eq;

  // Grant selection: round-robin in ARB, only the lock owner in LOCKED; data-independent.
  always_comb begin
    can_accept = !rsp_valid_q || i_rsp_ready;
    pick       = rr_pick(i_req_valid, rr_ptr_q);
    gnt_vld    = 1'b0;
    gnt_id     = '0;
    if (state_q == ARB) begin
      gnt_vld = pick[p_ID_W];
      gnt_id  = pick[p_ID_W-1:0];
    end else begin
      gnt_vld = i_req_valid[lock_id_q];
      gnt_id  = lock_id_q;
    end
    xfer        = gnt_vld && can_accept && !i_rst;
    o_req_ready = xfer ? (p_NUM_REQ'(1) << gnt_id) : '0;
  end

  // Operand mux feeding the shared ALU from the granted requester's slice.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int k = 0; k < p_NUM_REQ; k++) begin
      if (p_ID_W'(k) == gnt_id) begin
        a_sel  = i_req_a[k*p_WORD_LEN +: p_WORD_LEN];
        b_sel  = i_req_b[k*p_WORD_LEN +: p_WORD_LEN];
        op_sel = i_req_op[k];
      end
    end
  end

  alu_arbiter_alu #(
    .p_WORD_LEN(p_WORD_LEN)
  ) u_alu (
    .i_op (op_sel),
    .i_a  (a_sel),
    .i_b  (b_sel),
    .o_out(alu_out),
    .o_eq (alu_eq)
  );

  // Next state: lock/unlock on accepted transfers, response load/drain/hold.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_eq_d    = rsp_eq_q;
    if (xfer) begin
      if (i_req_lock[gnt_id]) begin
        state_d   = LOCKED;
        lock_id_d = gnt_id;
      end else begin
        state_d  = ARB;
        rr_ptr_d = (gnt_id == p_ID_W'(p_NUM_REQ - 1)) ? '0 : gnt_id + p_ID_W'(1);
      end
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_out_d   = alu_out;
      rsp_eq_d    = alu_eq;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State and response registers; reset discards any lock and pending response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_eq_q    <= rsp_eq_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_out   = rsp_out_q;
  assign o_rsp_eq    = rsp_eq_q;

endmodule
